// File: rtl/posedge_event_arbiter.sv
// Multi-channel rising-edge event counter with round-robin grant to one consumer.
// Define POSEDGE_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead.
module posedge_event_arbiter #(
  parameter int unsigned CH_W   = 2,
  parameter int unsigned PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 i_sclr,
  input  logic                 i_en,
  input  logic [(1<<CH_W)-1:0] i_dat,
  input  logic                 i_ack,
  output logic                 o_valid,
  output logic [CH_W-1:0]      o_ch,
  output logic                 o_ovf,
  output logic [(1<<CH_W)-1:0] o_pend
);

  localparam int unsigned N_CH = 1 << CH_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                ovf_q, ovf_d;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [N_CH-1:0]     prev_q, prev_d;
  logic [PEND_W-1:0]   cnt_q [N_CH];
  logic [PEND_W-1:0]   cnt_d [N_CH];
`ifndef POSEDGE_ARB_FIXED_PRIO_EN
  logic [CH_W-1:0]     ptr_q, ptr_d;
`endif

  logic [N_CH-1:0]     edge_c;
  logic [N_CH-1:0]     dec_c;
  logic [N_CH-1:0]     nz_c;
  logic                ack_c;
  logic                any_c;
  logic [CH_W-1:0]     win_c;

  assign ack_c  = valid_q & i_ack;
  assign edge_c = {N_CH{i_en}} & i_dat & ~prev_q;
  assign prev_d = i_en ? i_dat : prev_q;
  assign any_c  = |nz_c;

  always_comb begin
    nz_c  = '0;
    dec_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      nz_c[c]  = (cnt_q[c] != '0);
      dec_c[c] = ack_c && (ch_q == CH_W'(c));
    end
  end

  // Pending counters: edge and ack on the same channel cancel out.
  always_comb begin
    ovf_d  = ovf_q;
    pend_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (edge_c[c] && !dec_c[c]) begin
        if (cnt_q[c] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[c] = cnt_q[c] + PEND_W'(1);
      end else if (dec_c[c] && !edge_c[c]) begin
        cnt_d[c] = cnt_q[c] - PEND_W'(1);
      end
      pend_d[c] = (cnt_d[c] != '0);
    end
  end

`ifdef POSEDGE_ARB_FIXED_PRIO_EN
  always_comb begin
    win_c = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (nz_c[i]) win_c = CH_W'(i);
    end
  end
`else
  // Search starts one past the last granted channel and wraps.
  always_comb begin
    logic [CH_W-1:0] idx;
    logic            found;
    win_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = ptr_q + CH_W'(i);
      if (!found && nz_c[idx]) begin
        win_c = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (i_sclr) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_c) state_d = GRANT;
      GRANT:   if (i_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
`ifndef POSEDGE_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (any_c) begin
          valid_d = 1'b1;
          ch_d    = win_c;
        end
      end
      GRANT: begin
        valid_d = 1'b1;
        if (i_ack) begin
          valid_d = 1'b0;
`ifndef POSEDGE_ARB_FIXED_PRIO_EN
          ptr_d   = ch_q;
`endif
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      prev_q  <= '0;
`ifndef POSEDGE_ARB_FIXED_PRIO_EN
      ptr_q   <= CH_W'(N_CH - 1);
`endif
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
`ifndef POSEDGE_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign o_valid = valid_q;
  assign o_ch    = ch_q;
  assign o_ovf   = ovf_q;
  assign o_pend  = pend_q;

endmodule

// File: tb/tb_posedge_event_arbiter.sv
// Directed bench for posedge_event_arbiter; expected grant channels queued as stimulus is applied.
module tb_posedge_event_arbiter;

  localparam int unsigned CH_W = 2;
  localparam int unsigned N_CH = 4;

  logic            clk;
  logic            i_sclr;
  logic            i_en;
  logic [N_CH-1:0] i_dat;
  logic            i_ack;
  logic            o_valid;
  logic [CH_W-1:0] o_ch;
  logic            o_ovf;
  logic [N_CH-1:0] o_pend;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  posedge_event_arbiter #(.CH_W(CH_W), .PEND_W(2)) dut (
    .clk(clk), .i_sclr(i_sclr), .i_en(i_en), .i_dat(i_dat), .i_ack(i_ack),
    .o_valid(o_valid), .o_ch(o_ch), .o_ovf(o_ovf), .o_pend(o_pend)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_sclr = 1'b1; i_ack = 1'b0; i_dat = '0; i_en = 1'b1;
    tick();
    i_sclr = 1'b0;
  endtask

  // Wait (bounded) for a grant, compare its channel with the scoreboard, then ack it.
  task automatic serve(input string tag);
    int n;
    int e;
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ch"}, 32'(o_ch), 32'(e));
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk({tag, "_drop"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    clk = 1'b0; i_sclr = 1'b1; i_en = 1'b0; i_dat = '0; i_ack = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ch",    32'(o_ch),    32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_pend",  32'(o_pend),  32'd0);

    // Single channel held high: one event, no re-grant.
    i_sclr = 1'b0; i_en = 1'b1; i_dat = 4'b0001;
    tick();
    chk("t1_pend_e0", 32'(o_pend), 32'h1);
    chk("t1_valid_e0", 32'(o_valid), 32'd0);
    exp_q.push_back(0);
    tick();
    serve("t1");
    chk("t1_pend_after", 32'(o_pend), 32'h0);
    tick(); tick(); tick();
    chk("t1_no_regrant", 32'(o_valid), 32'd0);

    // All four rise together with ack tied high: 0,1,2,3 one bubble apart.
    do_reset();
    i_dat = 4'b1111; i_ack = 1'b1;
    tick();
    chk("t2_pend_e0", 32'(o_pend), 32'hF);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", 32'(o_valid), 32'd1);
      chk("t2_ch", 32'(o_ch), 32'(k));
      tick();
      chk("t2_bubble", 32'(o_valid), 32'd0);
      tick();
    end
    chk("t2_idle", 32'(o_valid), 32'd0);
    chk("t2_pend", 32'(o_pend), 32'h0);
    i_ack = 1'b0;

    // Channel 2 toggled four times without ack: saturate at 3, overflow sticky.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_dat = 4'b0100; tick();
      i_dat = 4'b0000; tick();
    end
    chk("t3_ovf", 32'(o_ovf), 32'd1);
    chk("t3_pend", 32'(o_pend), 32'h4);
    for (int k = 0; k < 3; k++) exp_q.push_back(2);
    serve("t3a"); serve("t3b"); serve("t3c");
    tick(); tick(); tick();
    chk("t3_no_4th", 32'(o_valid), 32'd0);
    chk("t3_pend_clr", 32'(o_pend), 32'h0);
    chk("t3_ovf_sticky", 32'(o_ovf), 32'd1);
    do_reset();
    tick();
    chk("t3_ovf_clr", 32'(o_ovf), 32'd0);

    // Edge on channel 1 in the same cycle as its ack: count stays 1.
    i_dat = 4'b0010; tick();
    i_dat = 4'b0000; tick();
    chk("t4_valid", 32'(o_valid), 32'd1);
    chk("t4_ch", 32'(o_ch), 32'd1);
    i_dat = 4'b0010; i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("t4_bubble", 32'(o_valid), 32'd0);
    chk("t4_pend", 32'(o_pend), 32'h2);
    exp_q.push_back(1);
    tick();
    chk("t4_regrant_valid", 32'(o_valid), 32'd1);
    serve("t4");
    chk("t4_pend_clr", 32'(o_pend), 32'h0);

    // i_en=0: no new events, channel 3 still served.
    do_reset();
    i_dat = 4'b1000; tick();
    i_en = 1'b0;
    i_dat = 4'b0111; tick();
    i_dat = 4'b0000; tick();
    i_dat = 4'b1111; tick();
    i_dat = 4'b0101; tick();
    chk("t5_pend_frozen", 32'(o_pend), 32'h8);
    exp_q.push_back(3);
    serve("t5");
    i_dat = 4'b1010; tick();
    i_dat = 4'b0101; tick(); tick();
    chk("t5_no_new", 32'(o_valid), 32'd0);
    chk("t5_pend_clr", 32'(o_pend), 32'h0);

    // Reset during GRANT cancels everything.
    i_en = 1'b1; i_dat = 4'b0000; tick();
    i_dat = 4'b0001; tick(); tick();
    chk("t6_granted", 32'(o_valid), 32'd1);
    i_sclr = 1'b1; tick();
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_pend", 32'(o_pend), 32'h0);
    i_sclr = 1'b0; i_dat = 4'b0000; tick();

    // Channel 0 with two events and channel 3 with one: arbitration order.
    do_reset();
    i_dat = 4'b1001; tick();
    i_dat = 4'b0000; tick();
    i_dat = 4'b0001; tick();
    i_dat = 4'b0000; tick();
`ifdef POSEDGE_ARB_FIXED_PRIO_EN
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3);
`else
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
`endif
    serve("t7a"); serve("t7b"); serve("t7c");
    tick();
    chk("t7_pend_clr", 32'(o_pend), 32'h0);
    chk("t7_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
